// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared types and constants for the CPU pipeline control logic.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO       = 5'd0;
    localparam int         MD_LATENCY_DEF = 4;

    // A load in EX feeds the ID instruction only if it writes a real register
    // that ID actually reads.
    function automatic logic load_use_hit(
        input logic       memread,
        input logic [4:0] ex_rt,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rs,
        input logic       uses_rt
    );
        return memread && (ex_rt != REG_ZERO) &&
               ((uses_rs && (rs == ex_rt)) || (uses_rt && (rt == ex_rt)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use / branch / mul-div hazard controller with
//               saturating stall and flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_lw,
    output logic             id_flush,
    output logic             id_exe_hold,
    output logic             ex_mem_bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MD_CW = 4;

    generate
        if ((MD_LATENCY < 2) || (MD_LATENCY > 15)) begin : g_bad_md_latency
            $error("hazard_ctrl: MD_LATENCY must be in 2..15");
        end
    endgenerate

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [MD_CW-1:0] md_cnt_q;
    logic [MD_CW-1:0] md_cnt_d;

    logic load_use;
    logic pc_stall_d;
    logic if_id_stall_d;
    logic if_id_flush_d;
    logic id_lw_d;
    logic id_flush_d;
    logic id_exe_hold_d;
    logic ex_mem_bubble_d;
    logic md_busy_d;
    logic md_done_d;

    assign load_use = load_use_hit(ex_memread, ex_rt, id_rs, id_rt,
                                   id_uses_rs, id_uses_rt);

    always_comb begin
        state_d         = state_q;
        md_cnt_d        = md_cnt_q;
        pc_stall_d      = 1'b0;
        if_id_stall_d   = 1'b0;
        if_id_flush_d   = 1'b0;
        id_lw_d         = 1'b0;
        id_flush_d      = 1'b0;
        id_exe_hold_d   = 1'b0;
        ex_mem_bubble_d = 1'b0;
        md_busy_d       = 1'b0;
        md_done_d       = 1'b0;

        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    if_id_flush_d = 1'b1;
                    id_flush_d    = 1'b1;
                end else if (ex_md_start) begin
                    pc_stall_d      = 1'b1;
                    if_id_stall_d   = 1'b1;
                    id_exe_hold_d   = 1'b1;
                    ex_mem_bubble_d = 1'b1;
                    md_busy_d       = 1'b1;
                    md_cnt_d        = MD_CW'(MD_LATENCY - 2);
                    state_d         = MD_WAIT;
                end else if (load_use) begin
                    pc_stall_d    = 1'b1;
                    if_id_stall_d = 1'b1;
                    id_lw_d       = 1'b1;
                end
            end

            MD_WAIT: begin
                pc_stall_d      = 1'b1;
                if_id_stall_d   = 1'b1;
                id_exe_hold_d   = 1'b1;
                ex_mem_bubble_d = 1'b1;
                md_busy_d       = 1'b1;
                if (md_cnt_q == '0) begin
                    // Last cycle: let the mul/div result flow into EX/MEM.
                    md_done_d       = 1'b1;
                    ex_mem_bubble_d = 1'b0;
                    state_d         = RUN;
                end else begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Inputs can still show a hazard during reset, so mask the controls.
    assign pc_stall      = reset & pc_stall_d;
    assign if_id_stall   = reset & if_id_stall_d;
    assign if_id_flush   = reset & if_id_flush_d;
    assign id_lw         = reset & id_lw_d;
    assign id_flush      = reset & id_flush_d;
    assign id_exe_hold   = reset & id_exe_hold_d;
    assign ex_mem_bubble = reset & ex_mem_bubble_d;
    assign md_busy       = reset & md_busy_d;
    assign md_done       = reset & md_done_d;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_stall),
        .count (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (id_flush),
        .count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    // Packed control order: pc_stall, if_id_stall, if_id_flush, id_lw,
    // id_flush, id_exe_hold, ex_mem_bubble, md_busy, md_done
    localparam logic [8:0] E_NONE = 9'b000000000;
    localparam logic [8:0] E_LU   = 9'b110100000;
    localparam logic [8:0] E_BR   = 9'b001010000;
    localparam logic [8:0] E_MD   = 9'b110001110;
    localparam logic [8:0] E_MDL  = 9'b110001011;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rs, id_uses_rt, ex_memread;
    logic             ex_branch_taken, ex_md_start;
    logic             pc_stall, if_id_stall, if_id_flush, id_lw, id_flush;
    logic             id_exe_hold, ex_mem_bubble, md_busy, md_done;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       mr;
        logic [4:0] ert;
        logic       br;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl [10];

    hazard_ctrl #(
        .MD_LATENCY (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_md_start     (ex_md_start),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_lw           (id_lw),
        .id_flush        (id_flush),
        .id_exe_hold     (id_exe_hold),
        .ex_mem_bubble   (ex_mem_bubble),
        .md_busy         (md_busy),
        .md_done         (md_done),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ctrl_vec();
        return {pc_stall, if_id_stall, if_id_flush, id_lw, id_flush,
                id_exe_hold, ex_mem_bubble, md_busy, md_done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic mr,
                         input logic [4:0] ert, input logic br, input logic md);
        id_rs           = rs;
        id_rt           = rt;
        id_uses_rs      = urs;
        id_uses_rt      = urt;
        ex_memread      = mr;
        ex_rt           = ert;
        ex_branch_taken = br;
        ex_md_start     = md;
    endtask

    // Check combinational controls mid-cycle, advance the counter model,
    // then step past the next rising edge.
    task automatic cyc(input string name, input logic [8:0] exp);
        @(negedge clk);
        chk(name, {23'd0, ctrl_vec()}, {23'd0, exp});
        if (exp[8] && exp_stall < 15) exp_stall++;
        if (exp[4] && exp_flush < 15) exp_flush++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_stall_cnt"}, {28'd0, stall_cnt}, exp_stall);
        chk({tag, "_flush_cnt"}, {28'd0, flush_cnt}, exp_flush);
    endtask

    initial begin
        tbl[0] = '{rs: 5'd0,  rt: 5'd0,  urs: 1'b0, urt: 1'b0, mr: 1'b0, ert: 5'd0,  br: 1'b0, exp: E_NONE};
        tbl[1] = '{rs: 5'd8,  rt: 5'd2,  urs: 1'b1, urt: 1'b0, mr: 1'b1, ert: 5'd8,  br: 1'b0, exp: E_LU};
        tbl[2] = '{rs: 5'd0,  rt: 5'd0,  urs: 1'b1, urt: 1'b1, mr: 1'b1, ert: 5'd0,  br: 1'b0, exp: E_NONE};
        tbl[3] = '{rs: 5'd1,  rt: 5'd5,  urs: 1'b0, urt: 1'b1, mr: 1'b1, ert: 5'd5,  br: 1'b0, exp: E_LU};
        tbl[4] = '{rs: 5'd1,  rt: 5'd5,  urs: 1'b1, urt: 1'b0, mr: 1'b1, ert: 5'd5,  br: 1'b0, exp: E_NONE};
        tbl[5] = '{rs: 5'd8,  rt: 5'd8,  urs: 1'b1, urt: 1'b1, mr: 1'b0, ert: 5'd8,  br: 1'b0, exp: E_NONE};
        tbl[6] = '{rs: 5'd8,  rt: 5'd2,  urs: 1'b1, urt: 1'b0, mr: 1'b1, ert: 5'd8,  br: 1'b1, exp: E_BR};
        tbl[7] = '{rs: 5'd0,  rt: 5'd0,  urs: 1'b0, urt: 1'b0, mr: 1'b0, ert: 5'd0,  br: 1'b1, exp: E_BR};
        tbl[8] = '{rs: 5'd3,  rt: 5'd6,  urs: 1'b1, urt: 1'b1, mr: 1'b1, ert: 5'd4,  br: 1'b0, exp: E_NONE};
        tbl[9] = '{rs: 5'd1,  rt: 5'd31, urs: 1'b1, urt: 1'b1, mr: 1'b1, ert: 5'd31, br: 1'b0, exp: E_LU};

        // Reset held with a live load-use on the inputs: controls must stay low.
        reset = 1'b0;
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        #12;
        chk("reset_ctrl", {23'd0, ctrl_vec()}, 32'd0);
        chk_cnts("reset");
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #10;
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].mr,
                  tbl[i].ert, tbl[i].br, 1'b0);
            cyc($sformatf("vec%0d", i), tbl[i].exp);
        end
        chk_cnts("table");

        // Mul/div: four busy cycles; a taken branch plus load-use in the
        // second cycle must be ignored.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc("md_c1", E_MD);
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1);
        cyc("md_c2", E_MD);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("md_c3", E_MD);
        cyc("md_c4", E_MDL);
        cyc("md_after", E_NONE);
        chk_cnts("md");

        // Saturation: stall_cnt must stop at 15.
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("sat%0d", i), E_LU);
        end
        chk("sat_stall_cnt", {28'd0, stall_cnt}, 32'd15);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc("sat_after", E_NONE);
        chk("sat_hold", {28'd0, stall_cnt}, 32'd15);

        // Reset in the second mul/div cycle: everything drops immediately.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc("mdr_c1", E_MD);
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("mdr_reset_ctrl", {23'd0, ctrl_vec()}, 32'd0);
        exp_stall = 0;
        exp_flush = 0;
        chk_cnts("mdr_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("mdr_release_idle", {23'd0, ctrl_vec()}, 32'd0);
        @(posedge clk);
        #1;
        cyc("mdr_idle", E_NONE);
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        cyc("mdr_lu", E_LU);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        cyc("mdr_br", E_BR);
        chk_cnts("mdr_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage CPU.
- Drives the stall, bubble and flush controls consumed by the PC, IF/ID and ID/EX registers:
  - id_lw (load-use bubble)
  - id_flush (branch squash)
  - front-end stall during multi-cycle mul/div
- Sits beside the ID stage. Inputs are ID-stage source registers and EX-stage status.
- Also keeps saturating performance counters for stall cycles and flushes.

Parameters:
- MD_LATENCY, 4, total EX cycles of a mul/div op (legal range 2..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_memread  in  1  EX instruction is a load (OR of MemRead_out bits)
- ex_rt  in  5  destination register of the EX load
- ex_branch_taken  in  1  EX branch/jump resolved taken
- ex_md_start  in  1  EX instruction is a multi-cycle mul/div, first EX cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID
- if_id_flush  out  1  zero IF/ID
- id_lw  out  1  insert bubble into ID/EX (load-use)
- id_flush  out  1  zero ID/EX (branch squash)
- id_exe_hold  out  1  hold ID/EX contents during mul/div
- ex_mem_bubble  out  1  insert bubble into EX/MEM during mul/div
- md_busy  out  1  mul/div wait in progress
- md_done  out  1  one-cycle pulse in last mul/div cycle
- stall_cnt  out  CNT_W  saturating count of cycles with pc_stall=1
- flush_cnt  out  CNT_W  saturating count of cycles with id_flush=1

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, md counter=0.
  - stall_cnt=0, flush_cnt=0.
  - All control outputs are 0 while reset is asserted.
- Hazard term: load_use = ex_memread & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- Control outputs are combinational from state and inputs, so they act in the same cycle the hazard is visible. State and counters update on the rising edge.
- States: RUN, MD_WAIT.
- RUN, evaluated in priority order:
  1. ex_branch_taken=1:
     - if_id_flush=1, id_flush=1.
     - id_lw=0, stalls=0 (the ID instruction is squashed, so no load-use bubble).
     - Stay in RUN.
  2. ex_md_start=1:
     - pc_stall=1, if_id_stall=1, id_exe_hold=1, ex_mem_bubble=1, md_busy=1.
     - Load md counter with MD_LATENCY-2.
     - Next state MD_WAIT.
     - load_use is ignored this cycle and re-evaluated after the wait.
  3. load_use=1:
     - pc_stall=1, if_id_stall=1, id_lw=1.
     - Stay in RUN. The next cycle EX holds a bubble, so the stall lasts exactly one cycle.
  4. Otherwise all controls are 0.
- MD_WAIT:
  - pc_stall, if_id_stall, id_exe_hold, ex_mem_bubble and md_busy are all 1.
  - ex_branch_taken, ex_md_start and load_use are ignored.
  - If counter==0: md_done=1, ex_mem_bubble=0 (the result proceeds), next state RUN.
  - Else decrement the counter.
  - Total front-end stall equals MD_LATENCY-1 cycles after the start cycle, i.e. MD_LATENCY cycles including the start cycle.
- Counters:
  - stall_cnt increments on every edge where pc_stall=1.
  - flush_cnt increments on every edge where id_flush=1.
  - Both hold at all-ones (no wrap).
- Out-of-range MD_LATENCY is a configuration error, caught by an elaboration-time check.
- Reset asserted mid-MD_WAIT returns immediately to RUN. No md_done pulse is produced.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding (RUN=1'b0, MD_WAIT=1'b1)
  - register-number constant REG_ZERO=5'd0
  - MD_LATENCY default
- One sub-module, sat_counter (parameter W; inputs clk, reset, inc; output count), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset: assert reset=0 mid-operation → all outputs 0 and counters 0 immediately. Release → RUN, all controls 0 with idle inputs.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8, id_uses_rs=1 for one cycle → id_lw=pc_stall=if_id_stall=1 for exactly that cycle, stall_cnt=1. Same with ex_rt=0 → no stall.
- Branch beats load-use: ex_branch_taken=1 with a load-use match → id_flush=if_id_flush=1, id_lw=0, pc_stall=0, flush_cnt increments by 1.
- Mul/div with MD_LATENCY=4: ex_md_start pulse → md_busy high 4 cycles, md_done only in the 4th, ex_mem_bubble high first 3 cycles, stall_cnt=4. A branch_taken injected in cycle 2 is ignored.
- Saturation with CNT_W=4: hold load-use for 20 cycles → stall_cnt stops at 15.
- Reset in MD_WAIT: assert reset in cycle 2 of a mul/div → md_busy=0 at once, no md_done. After release, RUN behaves normally.
